// File: rtl/memory_in.sv
// Single-port sample buffer for the regression datapath: byte-wide, write-first,
// registered read port; asynchronous active-low reset clears every stored word.
module memory_in #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;

  // Only reachable when DEPTH < 2**ADDR_W; such writes drop and reads return 0.
  assign in_range = (32'(addr) < 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      out <= '0;
    end else if (wr) begin
      if (in_range) mem[addr] <= data;
      out <= data;
    end else begin
      // An X on wr lands here, so an undefined enable behaves as a read.
      out <= in_range ? mem[addr] : '0;
    end
  end

endmodule

// File: tb/tb_memory_in.sv
// Directed-vector bench for memory_in: write-through, readback, overwrite,
// boundary addresses, asynchronous reset and hold behaviour.
module tb_memory_in;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic [DATA_W-1:0] out;

  int n_cmp = 0;
  int n_err = 0;

  memory_in #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .addr (addr),
    .wr   (wr),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one access, let the edge take it, sample 1 ns later.
  task automatic access(input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
    wr   = w;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill with write-through
    access(1'b1, 6'd0, 8'h01); chk("wr0_thru", out, 8'h01);
    access(1'b1, 6'd1, 8'h02); chk("wr1_thru", out, 8'h02);
    access(1'b1, 6'd2, 8'h03); chk("wr2_thru", out, 8'h03);

    // Readback
    access(1'b0, 6'd0, 8'hEE); chk("rd0", out, 8'h01);
    access(1'b0, 6'd1, 8'hEE); chk("rd1", out, 8'h02);
    access(1'b0, 6'd2, 8'hEE); chk("rd2", out, 8'h03);

    // Overwrite then immediate read of the same word
    access(1'b1, 6'd1, 8'h04); chk("ovw1_thru", out, 8'h04);
    access(1'b0, 6'd1, 8'h00); chk("ovw1_rd", out, 8'h04);
    access(1'b0, 6'd0, 8'h00); chk("ovw_rd0", out, 8'h01);
    access(1'b0, 6'd2, 8'h00); chk("ovw_rd2", out, 8'h03);

    // Last write wins
    access(1'b1, 6'd5, 8'h11); chk("ww5_a", out, 8'h11);
    access(1'b1, 6'd5, 8'h22); chk("ww5_b", out, 8'h22);
    access(1'b0, 6'd5, 8'h00); chk("ww5_rd", out, 8'h22);

    // Boundary addresses
    access(1'b1, 6'd63, 8'hAA); chk("wr63_thru", out, 8'hAA);
    access(1'b1, 6'd0,  8'h55); chk("wr0b_thru", out, 8'h55);
    access(1'b0, 6'd63, 8'h00); chk("rd63", out, 8'hAA);
    access(1'b0, 6'd0,  8'h00); chk("rd0b", out, 8'h55);
    access(1'b0, 6'd40, 8'h00); chk("rd40_unwritten", out, 8'h00);

    // Hold: read address 2 while data wiggles
    for (int i = 0; i < 5; i++) begin
      access(1'b0, 6'd2, 8'(8'hF0 + i));
      chk($sformatf("hold_%0d", i), out, 8'h03);
    end
    access(1'b0, 6'd3, 8'hFF); chk("rd3_unwritten", out, 8'h00);
    access(1'b0, 6'd2, 8'hFF); chk("hold_final", out, 8'h03);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 6'd1,  8'h00); chk("post_rst_rd1", out, 8'h00);
    access(1'b0, 6'd63, 8'h00); chk("post_rst_rd63", out, 8'h00);
    access(1'b0, 6'd0,  8'h00); chk("post_rst_rd0", out, 8'h00);
    access(1'b1, 6'd7,  8'h5A); chk("post_rst_wr7", out, 8'h5A);
    access(1'b0, 6'd7,  8'h00); chk("post_rst_rd7", out, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_in.md
Name: memory_in

Overview:
- Single-port synchronous RAM that buffers input samples (e.g. x/y data points) for the linear-regression datapath.
- An upstream loader writes bytes by address.
- The compute engine reads them back through a registered output port.
- One clock domain, asynchronous active-low reset that clears the whole array.

Parameters:
- DATA_W, 8, width of each stored word and of data/out.
- ADDR_W, 6, address width.
- DEPTH, 64 (2**ADDR_W), number of words. Must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active low.
- data  input  DATA_W  write data.
- addr  input  ADDR_W  shared read/write address.
- wr  input  1  write enable: 1 = write, 0 = read.
- out  output  DATA_W  registered read data.

Behaviour:
- Reset:
  - Interface is fixed: one clock, clk; reset rst_n, asynchronous, active low.
  - While rst_n = 0: all DEPTH entries read as 0 and out = 0, independent of clk.
  - First rising edge after deassertion operates normally.
  - A reset asserted mid-sequence discards all stored contents.
- Write (wr = 1 at a rising edge):
  - mem[addr] <= data.
  - Same edge: out <= data (write-through / write-first).
- Read (wr = 0 at a rising edge):
  - out <= mem[addr], i.e. the value at that address before this edge.
  - Memory is unchanged.
- Latency:
  - out reflects the address sampled at edge N, valid after edge N.
  - One cycle from address presentation to data.
  - No combinational path from addr/data/wr to out.
- out is held between edges. It always carries the result of the most recent access; there is no idle state.
- Out-of-range address (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Write is ignored.
  - Read returns 0.
  - Default config has no out-of-range addresses. addr 63 is a valid word; there is no wrap-around logic.
- Back-to-back accesses:
  - Write then read of the same address on consecutive edges returns the new data.
  - Consecutive writes to the same address: last write wins.
- Unwritten locations read 0 after reset.
- X on wr during a rising edge is a usage error. The implementation may treat it as a read; verification flags it.

Test Plan:
- Reset then fill: rst_n pulse low; write 0x01@0, 0x02@1, 0x03@2 on three consecutive edges -> out = 0x01, 0x02, 0x03 after each respective edge (write-through).
- Readback: wr = 0, addr 0, 1, 2 on consecutive edges -> out = 0x01, 0x02, 0x03, each one edge after the address is sampled.
- Overwrite: write 0x04@1, next edge read addr 1 -> out = 0x04 on both edges; addr 0 still reads 0x01 and addr 2 still reads 0x03.
- Boundaries: write 0xAA@63 and 0x55@0, read 63 then 0 -> 0xAA then 0x55. Read never-written addr 40 -> 0x00.
- Async reset mid-operation: after the writes above, drop rst_n between edges -> out goes 0x00 immediately without a clock edge. Release; read addr 1 -> 0x00.
- Hold: wr = 0, addr held at 2 for 5 cycles -> out stays 0x03. Changing data while wr = 0 has no effect on memory.
